// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the bit-counter sizing helper.
package bit_serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    // A 1-bit operand still needs a 1-bit counter so the port list stays legal.
    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_behavioral.sv
// Single-bit full adder cell; the serial adder reuses one of these per bit-cycle.
module full_adder_behavioral (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry looped
// back through a flop, result and carry-out registered on the final bit.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] next_s;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            fa_sum;
    logic            fa_cout;

    full_adder_behavioral u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry)
    );

    // Written as shift-then-overwrite so WIDTH=1 needs no special slice.
    always_comb begin
        next_s          = s_reg >> 1;
        next_s[WIDTH-1] = fa_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                        s_reg <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    s_reg <= next_s;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= next_s;
                        cout  <= fa_cout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized scoreboard bench for bit_serial_adder with a cycle-level
// transaction model of acceptance, latency and result holding.
module tb_bit_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W:0] res;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail = 0;

    exp_t       q[$];
    int         skip = 0;
    int         cyc = 0;
    bit         done_exp = 1'b0;
    logic [W:0] cur_res = '0;
    logic [W:0] prev_res = '0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction model: an accepted start occupies W edges, then the
    // machine is free again (DONE accepts a new start like IDLE).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            skip     = 0;
            done_exp = 1'b0;
            prev_res = '0;
            q.delete();
        end else begin
            cyc++;
            done_exp = 1'b0;
            if (skip > 0) begin
                skip--;
                if (skip == 0) begin
                    done_exp = 1'b1;
                    prev_res = cur_res;
                end
            end else if (start) begin
                cur_res = a + b + cin;
                q.push_back('{res: cur_res, cyc: cyc});
                skip = W;
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("busy", busy, skip > 0);
            chk("done", done, done_exp);
            chk("busy_done_excl", busy & done, 1'b0);
            chk("result_hold", {cout, sum}, prev_res);
            if (done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done got=1 exp=0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("sb_result", {cout, sum}, e.res);
                    chk("sb_latency", cyc - e.cyc, W);
                end
            end
        end
    end

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input logic [W:0] exp, input string nm);
        int bc;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; cin = $urandom;
        bc = 0;
        repeat (W + 2) begin
            if (busy) bc++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, bc, W);
        chk(nm, {cout, sum}, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_cout", cout, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        op(8'h00, 8'h00, 1'b0, 9'h000, "zero");
        op(8'hFF, 8'h01, 1'b0, 9'h100, "ff_plus_1");
        op(8'h7F, 8'h80, 1'b0, 9'h0FF, "7f_plus_80");
        op(8'hA5, 8'h5A, 1'b1, 9'h100, "a5_5a_c1");

        // Continuous start: only operands at accepted edges matter.
        @(negedge clk);
        start = 1'b1;
        repeat ((W + 1) * 4) begin
            a = $urandom; b = $urandom; cin = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Asynchronous reset at bit 4 of a run.
        @(negedge clk);
        start = 1'b1; a = 8'h3C; b = 8'hC3; cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_sum", sum, '0);
        chk("arst_cout", cout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        op(8'h12, 8'h34, 1'b1, 9'h047, "post_reset");

        // Random ops with random gaps, including starts landing in DONE.
        repeat (200) begin
            int g;
            @(negedge clk);
            start = 1'b1; a = $urandom; b = $urandom; cin = $urandom;
            @(negedge clk);
            start = 1'b0; a = $urandom; b = $urandom;
            g = $urandom_range(0, W + 3);
            repeat (g) @(negedge clk);
        end
        repeat (W + 3) @(negedge clk);
        chk("sb_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial N-bit adder that sits directly around the team's single-bit full adder cell. It accepts two WIDTH-bit operands plus a carry-in on a start strobe and feeds the full adder one bit pair per clock, LSB first. The carry-out is registered back as the next carry-in. After WIDTH bit-cycles it presents the WIDTH-bit sum and final carry-out with a one-cycle done pulse. It trades WIDTH cycles of latency for a single full-adder cell.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 1..32.

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-high; forces all state and outputs to reset values
- start  input  1  request strobe; sampled only when accepted (see Operation)
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  initial carry-in; captured on the accepted start edge
- busy  output  1  high while an addition is in progress (state RUN)
- done  output  1  one-cycle pulse (state DONE); result valid
- sum  output  WIDTH  registered result; holds the last completed value
- cout  output  1  registered final carry-out; holds the last completed value

## Operation
- Reset values:
  - state IDLE
  - busy=0, done=0, sum=0, cout=0
  - operand shift registers, sum shift register, carry flop and bit counter all 0
- States:
  - IDLE
    - start=1 loads the A and B shift registers and sets carry flop = cin.
    - Clears the bit counter and the sum shift register, then moves to RUN.
    - start=0: remain in IDLE.
  - RUN
    - Each cycle the full adder sees the LSB of the A register, the LSB of the B register, and the carry flop.
    - Each edge:
      - shift A and B right by one;
      - shift the full-adder sum bit into the MSB of the sum shift register, right-shifting it;
      - carry flop <= full-adder cout;
      - counter increments.
    - On the edge where the counter reaches WIDTH-1 (the WIDTH-th bit):
      - sum <= final shifted value;
      - cout <= full-adder cout;
      - move to DONE.
    - start is ignored in RUN.
  - DONE
    - done=1 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back) and moves to RUN.
    - Otherwise move to IDLE.
- Arithmetic: {cout, sum} == a + b + cin, computed modulo 2^(WIDTH+1) with no saturation.
- sum and cout change only on the completing edge or on reset. During RUN they hold the previous result.
- Operand inputs are don't-care except on the accepted start edge.
- Reset mid-operation: immediate return to IDLE with reset values.
  - No done pulse for the aborted addition.
  - sum and cout read 0.
- WIDTH=1: RUN lasts one cycle.

## Timing
- Accepted start at edge E0 (state becomes RUN).
- Bits are consumed in the cycles following edges E0..E0+WIDTH-1.
- The result registers update at edge E0+WIDTH, which is also when the state becomes DONE.
- done is high during the cycle between E0+WIDTH and E0+WIDTH+1.
- Latency from the start edge to the done cycle is WIDTH cycles.
- busy is high for exactly WIDTH cycles per operation.
- Throughput with back-to-back starts accepted in DONE is one result per WIDTH+1 cycles.
- busy and done are never high together. Both are decoded directly from registered state, so there is no combinational path from inputs.

## Structure
- Shared package bit_serial_adder_pkg:
  - state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - constant for the default WIDTH;
  - counter width function/constant ($clog2 of WIDTH, minimum 1).
- One sub-module, full_adder_behavioral, instantiated once.
  - Ports: sum, cout, a, b, cin.
  - Purely combinational; all sequencing lives in bit_serial_adder.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0, start one cycle → busy high 8 cycles; done pulse on cycle 8 after start edge; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x7F, b=0x80, cin=0 → sum=0xFF, cout=0.
- a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Additionally, sum holds the previous result throughout RUN.
- start held high continuously with changing a/b → only the operands at accepted edges are used. Each result matches a+b+cin of the captured values, with a done pulse every 9 cycles.
- Reset asserted asynchronously at bit 4 of a run → busy, done, sum and cout go 0 without waiting for clk. No done pulse. The next start after reset release completes correctly.
- 200 random a/b/cin with random start gaps (including starts in DONE) → every done pulse matches a scoreboard {cout,sum} = a+b+cin. The DONE-state start also checks busy/done mutual exclusion.
